// File: rtl/hs_reg_pipeline_rx_if.sv
// Valid/ready bus for hs_reg_pipeline_rx: producer side (dataIn*) and consumer side (dataOut*).
// The pipeline connects through the slave modport; the environment drives the master modport.
interface hs_reg_pipeline_rx_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] dataIn;
   logic                  dataIn_vld;
   logic                  dataIn_rd;
   logic [DATA_WIDTH-1:0] dataOut;
   logic                  dataOut_vld;
   logic                  dataOut_rd;

   modport master (
      output dataIn, dataIn_vld, dataOut_rd,
      input  dataIn_rd, dataOut, dataOut_vld
   );

   modport slave (
      input  dataIn, dataIn_vld, dataOut_rd,
      output dataIn_rd, dataOut, dataOut_vld
   );
endinterface

// File: rtl/hs_reg_pipeline_rx.sv
// Registered valid/ready pipeline of DEPTH skid stages; both valid and ready are registered.
// Optional macro HS_REG_PIPELINE_OCCUPANCY_EN adds a registered word-count port.
module hs_reg_pipeline_rx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
   output logic [$clog2(2*DEPTH+1)-1:0]   occupancy,
`endif
   hs_reg_pipeline_rx_if.slave            bus
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} stage_st_e;

   if (DEPTH < 1) begin : g_bad_depth
      $error("hs_reg_pipeline_rx: DEPTH must be at least 1");
   end

   // Per-stage outputs, indexed by stage; stage k output feeds stage k+1 input.
   logic                  st_vld  [DEPTH];
   logic [DATA_WIDTH-1:0] st_data [DEPTH];
   logic                  st_rd   [DEPTH];
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
   logic [1:0]            st_cnt_d [DEPTH];
`endif

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      stage_st_e             st_q, st_d;
      logic [DATA_WIDTH-1:0] main_q, main_d;
      logic [DATA_WIDTH-1:0] skid_q, skid_d;
      logic                  rd_q;
      logic                  in_vld;
      logic [DATA_WIDTH-1:0] in_data;
      logic                  out_rd;
      logic                  in_xfer;
      logic                  out_xfer;

      if (k == 0) begin : g_head
         assign in_vld  = bus.dataIn_vld;
         assign in_data = bus.dataIn;
      end else begin : g_body
         assign in_vld  = st_vld[k-1];
         assign in_data = st_data[k-1];
      end

      if (k == DEPTH - 1) begin : g_tail
         assign out_rd = bus.dataOut_rd;
      end else begin : g_mid
         assign out_rd = st_rd[k+1];
      end

      // rd_q is low in TWO, so in_xfer never fires there and data is only sampled when valid.
      assign in_xfer  = in_vld & rd_q;
      assign out_xfer = (st_q != StEmpty) & out_rd;

      always_comb begin
         st_d   = st_q;
         main_d = main_q;
         skid_d = skid_q;
         unique case (st_q)
            StEmpty: begin
               if (in_xfer) begin
                  st_d   = StOne;
                  main_d = in_data;
               end
            end
            StOne: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_data;
               end else if (in_xfer) begin
                  st_d   = StTwo;
                  skid_d = in_data;
               end else if (out_xfer) begin
                  st_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_xfer) begin
                  st_d   = StOne;
                  main_d = skid_q;
               end
            end
            default: st_d = StEmpty;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q   <= StEmpty;
            main_q <= '0;
            skid_q <= '0;
            rd_q   <= 1'b0;
         end else begin
            st_q   <= st_d;
            main_q <= main_d;
            skid_q <= skid_d;
            rd_q   <= (st_d != StTwo);
         end
      end

      assign st_vld[k]  = (st_q != StEmpty);
      assign st_data[k] = main_q;
      assign st_rd[k]   = rd_q;
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
      assign st_cnt_d[k] = (st_d == StTwo) ? 2'd2 : ((st_d == StOne) ? 2'd1 : 2'd0);
`endif
   end

   assign bus.dataIn_rd   = st_rd[0];
   assign bus.dataOut     = st_data[DEPTH-1];
   assign bus.dataOut_vld = st_vld[DEPTH-1];

`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
   localparam int unsigned OccW = $clog2(2*DEPTH+1);

   logic [OccW-1:0] occ_d, occ_q;

   // Summed from next states so the count moves on the same edge as the stages.
   always_comb begin
      occ_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_d = occ_d + OccW'(st_cnt_d[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_hs_reg_pipeline_rx.sv
// Self-checking bench for hs_reg_pipeline_rx (DATA_WIDTH=8, DEPTH=2): cycle table,
// streaming, randomized traffic against a queue model, and asynchronous reset.
module tb_hs_reg_pipeline_rx;

   logic clk;
   logic rst_n;
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
   logic [2:0] occupancy;
`endif

   hs_reg_pipeline_rx_if #(.DATA_WIDTH(8)) bus ();

   hs_reg_pipeline_rx #(
      .DATA_WIDTH(8),
      .DEPTH     (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
      .occupancy(occupancy),
`endif
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] din;
      logic       vld;
      logic       out_rd;
      logic       exp_vld;
      logic [7:0] exp_data;
      logic       chk_data;
      logic       exp_in_rd;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [7:0] din, input logic vld, input logic ord,
                      input logic ev, input logic [7:0] ed, input logic cd, input logic erd);
      vec_t v;
      v.din = din; v.vld = vld; v.out_rd = ord;
      v.exp_vld = ev; v.exp_data = ed; v.chk_data = cd; v.exp_in_rd = erd;
      tbl.push_back(v);
   endtask

   initial begin
      logic [7:0] model_q[$];
      logic [7:0] got[$];
      int         first_cyc, last_cyc, n, sent, recv, cyc;
      logic       pending, in_x, out_x, prev_hold, rd_s, done;
      logic [7:0] pend_data, prev_data, exp_w;

      // Single word A5, then full stall of 8'h10.. and release.
      add(8'hA5, 1, 1, 0, 8'h00, 0, 1);
      add(8'h00, 0, 1, 0, 8'h00, 0, 1);
      add(8'h00, 0, 1, 1, 8'hA5, 1, 1);
      add(8'h10, 1, 0, 0, 8'hA5, 1, 1);
      add(8'h11, 1, 0, 0, 8'h00, 0, 1);
      add(8'h12, 1, 0, 1, 8'h10, 1, 1);
      add(8'h13, 1, 0, 1, 8'h10, 1, 1);
      add(8'h14, 1, 0, 1, 8'h10, 1, 0);
      add(8'h14, 1, 0, 1, 8'h10, 1, 0);
      add(8'h14, 1, 1, 1, 8'h10, 1, 0);
      add(8'h14, 1, 1, 1, 8'h11, 1, 0);
      add(8'h14, 1, 1, 1, 8'h12, 1, 1);
      add(8'h15, 1, 1, 1, 8'h13, 1, 1);
      add(8'h00, 0, 1, 1, 8'h14, 1, 1);
      add(8'h00, 0, 1, 1, 8'h15, 1, 1);
      add(8'h00, 0, 1, 0, 8'h00, 0, 1);

      // Reset
      rst_n = 1'b0;
      bus.dataIn = 8'h00;
      bus.dataIn_vld = 1'b0;
      bus.dataOut_rd = 1'b0;
      repeat (3) step();
      check("reset_out_vld", 32'(bus.dataOut_vld), 32'd0);
      check("reset_out_data", 32'(bus.dataOut), 32'h00);
      check("reset_in_rd", 32'(bus.dataIn_rd), 32'd0);
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
      check("reset_occupancy", 32'(occupancy), 32'd0);
`endif
      rst_n = 1'b1;
      check("release_in_rd_before_edge", 32'(bus.dataIn_rd), 32'd0);
      step();
      check("release_in_rd_after_edge", 32'(bus.dataIn_rd), 32'd1);

      // Cycle table
      for (int i = 0; i < tbl.size(); i++) begin
         bus.dataIn     = tbl[i].din;
         bus.dataIn_vld = tbl[i].vld;
         bus.dataOut_rd = tbl[i].out_rd;
         check($sformatf("tbl%0d_out_vld", i), 32'(bus.dataOut_vld), 32'(tbl[i].exp_vld));
         check($sformatf("tbl%0d_in_rd", i), 32'(bus.dataIn_rd), 32'(tbl[i].exp_in_rd));
         if (tbl[i].chk_data)
            check($sformatf("tbl%0d_out_data", i), 32'(bus.dataOut), 32'(tbl[i].exp_data));
         step();
      end

      // Streaming 00..0F at full rate
      first_cyc = -1;
      last_cyc = -1;
      for (int i = 0; i < 22; i++) begin
         bus.dataIn     = 8'(i);
         bus.dataIn_vld = (i < 16);
         bus.dataOut_rd = 1'b1;
         if (i < 16) check($sformatf("stream_in_rd_c%0d", i), 32'(bus.dataIn_rd), 32'd1);
         if (bus.dataOut_vld) begin
            got.push_back(bus.dataOut);
            if (first_cyc < 0) first_cyc = i;
            last_cyc = i;
         end
         step();
      end
      check("stream_count", 32'(got.size()), 32'd16);
      check("stream_contiguous", 32'(last_cyc - first_cyc), 32'd15);
      check("stream_latency", 32'(first_cyc), 32'd2);
      for (int j = 0; j < got.size() && j < 16; j++)
         check($sformatf("stream_word%0d", j), 32'(got[j]), 32'(j));

      // Randomized traffic against a FIFO model
      sent = 0;
      recv = 0;
      cyc = 0;
      pending = 1'b0;
      pend_data = 8'h00;
      prev_hold = 1'b0;
      prev_data = 8'h00;
      while (recv < 1000 && cyc < 20000) begin
         if (!pending && sent < 1000 && ($urandom % 2 == 0)) begin
            pending = 1'b1;
            pend_data = 8'($urandom);
         end
         bus.dataIn     = pending ? pend_data : 8'hxx;
         bus.dataIn_vld = pending;
         bus.dataOut_rd = ($urandom % 2 == 0);
         if (prev_hold) begin
            check("rand_hold_vld", 32'(bus.dataOut_vld), 32'd1);
            check("rand_hold_data", 32'(bus.dataOut), 32'(prev_data));
         end
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
         check("rand_occupancy", 32'(occupancy), 32'(model_q.size()));
`endif
         check("rand_capacity", 32'(model_q.size() <= 4), 32'd1);
         in_x  = pending && bus.dataIn_rd;
         out_x = bus.dataOut_vld && bus.dataOut_rd;
         if (out_x) begin
            if (model_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL rand_spurious: got 0x%0h expected no word", bus.dataOut);
            end else begin
               exp_w = model_q.pop_front();
               check($sformatf("rand_word%0d", recv), 32'(bus.dataOut), 32'(exp_w));
            end
            recv++;
         end
         if (in_x) begin
            model_q.push_back(pend_data);
            sent++;
         end
         prev_hold = bus.dataOut_vld && !bus.dataOut_rd;
         prev_data = bus.dataOut;
         step();
         if (in_x) pending = 1'b0;
         cyc++;
      end
      check("rand_all_received", 32'(recv), 32'd1000);
      check("rand_model_empty", 32'(model_q.size()), 32'd0);

      // Fill with consumer stalled, then assert reset between edges
      bus.dataIn_vld = 1'b0;
      bus.dataOut_rd = 1'b1;
      repeat (4) step();
      n = 0;
      for (int i = 0; i < 8; i++) begin
         bus.dataIn     = 8'(32'h20 + n);
         bus.dataIn_vld = 1'b1;
         bus.dataOut_rd = 1'b0;
         rd_s = bus.dataIn_rd;
         step();
         if (rd_s) n++;
      end
      bus.dataIn_vld = 1'b0;
      check("stall_accepted", 32'(n), 32'd4);
      check("stall_in_rd", 32'(bus.dataIn_rd), 32'd0);
      check("stall_out_vld", 32'(bus.dataOut_vld), 32'd1);
      check("stall_out_data", 32'(bus.dataOut), 32'h20);
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
      check("stall_occupancy", 32'(occupancy), 32'd4);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out_vld", 32'(bus.dataOut_vld), 32'd0);
      check("async_out_data", 32'(bus.dataOut), 32'h00);
      check("async_in_rd", 32'(bus.dataIn_rd), 32'd0);
`ifdef HS_REG_PIPELINE_OCCUPANCY_EN
      check("async_occupancy", 32'(occupancy), 32'd0);
`endif
      repeat (2) step();
      rst_n = 1'b1;
      bus.dataOut_rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("post_reset_idle%0d", i), 32'(bus.dataOut_vld), 32'd0);
         step();
      end
      bus.dataIn = 8'h77;
      bus.dataIn_vld = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         rd_s = bus.dataIn_rd;
         step();
         done = rd_s;
      end
      bus.dataIn_vld = 1'b0;
      check("post_reset_accepted", 32'(done), 32'd1);
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (bus.dataOut_vld) done = 1'b1;
         else step();
      end
      check("post_reset_out_vld", 32'(done), 32'd1);
      check("post_reset_first_word", 32'(bus.dataOut), 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
